shift_seq_ctrl: RTL and testbench
=================================

# shift_seq_ctrl

Command-driven sequencer for the team's 4-bit bidirectional shift register. It accepts a load word, a direction and a shift count over a valid/ready handshake, then loads the register and steps it the requested number of times. While stepping it streams the outgoing bit on `sout` and shifts `sin` into the vacated position. It sits between a host/command source and the serial pins, giving parallel-to-serial and serial-to-parallel conversion with a completion pulse.

## Interface
Parameters:
- `WIDTH`, default 4: shift register width.
- `CNT_W`, default `$clog2(WIDTH)+1`: width of the shift count (derived; do not override).

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  high only in IDLE; a command is accepted on an edge where `cmd_valid && cmd_ready`.
- `cmd_data`  in  WIDTH  word to parallel-load.
- `cmd_dir`  in  1  1 = shift left (toward MSB), 0 = shift right.
- `cmd_count`  in  CNT_W  number of shifts, 0..WIDTH; values above WIDTH saturate to WIDTH at capture.
- `abort`  in  1  synchronous cancel of the current command.
- `sin`  in  1  serial input, sampled on each shift edge.
- `sout`  out  1  outgoing bit: `q[WIDTH-1]` when left, `q[0]` when right; 0 outside SHIFT.
- `sout_valid`  out  1  high in every SHIFT cycle.
- `busy`  out  1  high in LOAD and SHIFT.
- `done`  out  1  one-cycle pulse in the DONE state.
- `result`  out  WIDTH  current register contents at all times.

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE: `cmd_ready`=1. On handshake, capture dir and saturated count and go to LOAD.
- LOAD: drive load to the register. At the next edge, `q <= cmd_data` (captured). Go to SHIFT if count>0, else DONE.
- SHIFT: each edge performs one shift and decrements the remaining count.
  - Left: `q <= {q[WIDTH-2:0], sin}`.
  - Right: `q <= {sin, q[WIDTH-1:1]}`.
  - Go to DONE at the edge where the remaining count reaches 0.
- DONE: `done`=1 and `result` holds the final word. Next edge goes to IDLE; the register holds its value.
- The register changes only in LOAD and SHIFT; it holds in IDLE and DONE.
- Abort: when `abort`=1 at an edge in LOAD or SHIFT, go to IDLE. No `done` is issued and the register keeps its value as of that edge (no load or shift occurs on it). `abort` is ignored in IDLE and DONE.
- Reset, asynchronous and any time including mid-SHIFT:
  - State IDLE, register 0, remaining count 0.
  - Outputs: `cmd_ready`=1, `busy`=0, `done`=0, `sout`=0, `sout_valid`=0, `result`=0.

## Timing
- Handshake at edge E0. LOAD in cycle 1. SHIFT in cycles 2..count+1. DONE in cycle count+2.
- count=0 gives `done` in cycle 2 with no `sout_valid`.
- The earliest next accept is the edge ending the first IDLE cycle after DONE, so the command period is count+3 cycles.
- `sout` is combinational from the register and the captured dir. It is valid throughout each SHIFT cycle and is the bit leaving at that cycle's closing edge.
- All other outputs are decoded from registered state; there are no combinational paths from inputs to outputs.

## Structure
- Package `shift_ctrl_pkg`:
  - State encoding: IDLE=2'd0, LOAD=2'd1, SHIFT=2'd2, DONE=2'd3.
  - Constants DIR_LEFT=1'b1, DIR_RIGHT=1'b0.
- One sub-module `shift_reg_core`: a WIDTH-bit register with load, dir, serial-in and hold enable.
  - It uses the shared async reset.
  - The controller owns the FSM, count and captured dir.

## Test plan
- Reset mid-operation: accept `cmd_data`=4'b1011, left, count=4; assert `rst` during the second SHIFT cycle -> IDLE, `result`=0, `cmd_ready`=1, no `done`.
- Left shift: `cmd_data`=4'b1011, left, count=2, `sin`=0 then 1 -> `sout` 1 then 0; `result`=4'b1101; `done` in cycle 4 after handshake.
- Right shift: `cmd_data`=4'b0110, right, count=4, `sin`=1 -> `sout` 0,1,1,0; `result`=4'b1111; `done` in cycle 6.
- Count boundaries:
  - count=0 with 4'b1001 -> `result`=4'b1001, `done` in cycle 2, no `sout_valid`.
  - count=7 -> exactly 4 shifts.
- Abort: left, count=4, `abort` at the edge ending the second SHIFT cycle -> exactly 1 shift applied, no `done`, `busy` low and `cmd_ready` high next cycle.
- Back-to-back: `cmd_valid` held high with two commands -> `cmd_ready` low from LOAD through DONE; second command accepted at the edge ending the first IDLE cycle after DONE.

Source files
------------

// File: rtl/shift_ctrl_pkg.sv
// rtl/shift_ctrl_pkg.sv - shared state encoding and direction constants for the shift sequencer
package shift_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

endpackage

// File: rtl/shift_reg_core.sv
// rtl/shift_reg_core.sv - WIDTH-bit bidirectional shift register with parallel load
// Load has priority over shift; with neither asserted the register holds.
module shift_reg_core
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             en_i,
  input  logic             dir_i,
  input  logic             sin_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = d_i;
    end else if (en_i) begin
      q_d = (dir_i == DIR_LEFT) ? {q_q[WIDTH-2:0], sin_i} : {sin_i, q_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - command sequencer: load word, then shift it count times
// Owns the FSM, remaining count and captured command; the register lives in shift_reg_core.
module shift_seq_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             abort,
  input  logic             sin,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             load, shift_en;
  logic [WIDTH-1:0] q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    data_d   = data_q;
    load     = 1'b0;
    shift_en = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          dir_d   = cmd_dir;
          data_d  = cmd_data;
          cnt_d   = (cmd_count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : cmd_count;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // An abort on this edge suppresses the load entirely.
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          load    = 1'b1;
          state_d = (cnt_q != '0) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          shift_en = 1'b1;
          cnt_d    = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dir_q   <= DIR_RIGHT;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      data_q  <= data_d;
    end
  end

  shift_reg_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .en_i   (shift_en),
    .dir_i  (dir_q),
    .sin_i  (sin),
    .d_i    (data_q),
    .q_o    (q)
  );

  assign cmd_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q == ST_LOAD) || (state_q == ST_SHIFT);
  assign done       = (state_q == ST_DONE);
  assign sout_valid = (state_q == ST_SHIFT);
  assign sout       = sout_valid && ((dir_q == DIR_LEFT) ? q[WIDTH-1] : q[0]);
  assign result     = q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - self-checking bench for shift_seq_ctrl
module tb_shift_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_data;
  logic       cmd_dir;
  logic [2:0] cmd_count;
  logic       abort;
  logic       sin;
  logic       sout;
  logic       sout_valid;
  logic       busy;
  logic       done;
  logic [3:0] result;

  int n_checks = 0;
  int n_pass   = 0;

  shift_seq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_data   (cmd_data),
    .cmd_dir    (cmd_dir),
    .cmd_count  (cmd_count),
    .abort      (abort),
    .sin        (sin),
    .sout       (sout),
    .sout_valid (sout_valid),
    .busy       (busy),
    .done       (done),
    .result     (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: the register is an integer 0..15; left = (r*2 + sin) mod 16, right = r/2 + 8*sin.
  task automatic run_cmd(input logic [3:0] data, input logic dir, input logic [2:0] count,
                         input logic [7:0] sin_bits, input int abort_at);
    int m;
    int n;
    n = (count > 3'd4) ? 4 : int'(count);
    cmd_valid = 1'b1; cmd_data = data; cmd_dir = dir; cmd_count = count; abort = 1'b0; sin = 1'b0;
    chk("idle_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0; cmd_data = 4'($urandom); cmd_dir = 1'($urandom); cmd_count = 3'($urandom);
    chk("load_busy", busy, 1);
    chk("load_ready", cmd_ready, 0);
    chk("load_svalid", sout_valid, 0);
    step();
    m = int'(data);
    for (int k = 0; k < n; k++) begin
      chk("shift_svalid", sout_valid, 1);
      chk("shift_done", done, 0);
      chk("shift_sout", sout, dir ? m / 8 : m % 2);
      chk("shift_result", result, m);
      sin = sin_bits[k];
      if (k + 1 == abort_at) begin
        abort = 1'b1;
        step();
        abort = 1'b0;
        sin = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_ready", cmd_ready, 1);
        chk("abort_done", done, 0);
        chk("abort_result", result, m);
        step();
        chk("abort_done2", done, 0);
        chk("abort_hold", result, m);
        return;
      end
      m = dir ? (m * 2 + int'(sin_bits[k])) % 16 : m / 2 + 8 * int'(sin_bits[k]);
      step();
    end
    sin = 1'b0;
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    chk("done_ready", cmd_ready, 0);
    chk("done_svalid", sout_valid, 0);
    chk("done_sout", sout, 0);
    chk("done_result", result, m);
    step();
    chk("post_done", done, 0);
    chk("post_ready", cmd_ready, 1);
    chk("post_hold", result, m);
  endtask

  initial begin
    int dones;
    int n;
    rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; cmd_dir = 1'b0; cmd_count = '0;
    abort = 1'b0; sin = 1'b0;
    #12;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sout", sout, 0);
    chk("rst_svalid", sout_valid, 0);
    chk("rst_result", result, 0);
    step();
    rst = 1'b0;
    step();

    // Reset during the second SHIFT cycle of a left count=4 command
    cmd_valid = 1'b1; cmd_data = 4'b1011; cmd_dir = 1'b1; cmd_count = 3'd4;
    step();
    cmd_valid = 1'b0;
    step();
    sin = 1'b1;
    step();
    chk("mid_before", sout_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_result", result, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_svalid", sout_valid, 0);
    chk("mid_rst_done", done, 0);
    step();
    rst = 1'b0; sin = 1'b0;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done) dones++;
    end
    chk("mid_rst_no_done", dones, 0);
    chk("mid_rst_idle", cmd_ready, 1);

    run_cmd(4'b1011, 1'b1, 3'd2, 8'b10, 0);
    run_cmd(4'b0110, 1'b0, 3'd4, 8'hFF, 0);
    run_cmd(4'b1001, 1'b1, 3'd0, 8'h00, 0);
    run_cmd(4'b1001, 1'b0, 3'd0, 8'hFF, 0);
    run_cmd(4'b0011, 1'b1, 3'd7, 8'b0101, 0);
    run_cmd(4'b1100, 1'b0, 3'd5, 8'b1010, 0);
    run_cmd(4'b1011, 1'b1, 3'd4, 8'hFF, 2);

    // Back-to-back with cmd_valid held high
    cmd_valid = 1'b1; cmd_data = 4'b1100; cmd_dir = 1'b1; cmd_count = 3'd1;
    chk("b2b_ready0", cmd_ready, 1);
    step();
    cmd_data = 4'b0101; cmd_dir = 1'b0; cmd_count = 3'd0;
    chk("b2b_load_ready", cmd_ready, 0);
    step();
    chk("b2b_shift_ready", cmd_ready, 0);
    chk("b2b_shift_sout", sout, 1);
    step();
    chk("b2b_done_ready", cmd_ready, 0);
    chk("b2b_done", done, 1);
    chk("b2b_result_a", result, 4'b1000);
    step();
    chk("b2b_idle_ready", cmd_ready, 1);
    chk("b2b_idle_done", done, 0);
    step();
    cmd_valid = 1'b0;
    chk("b2b_second_load", busy, 1);
    step();
    chk("b2b_second_done", done, 1);
    chk("b2b_result_b", result, 4'b0101);
    step();

    for (int i = 0; i < 40; i++) begin
      logic [2:0] c;
      int ab;
      c = 3'($urandom_range(0, 7));
      n = (c > 3'd4) ? 4 : int'(c);
      ab = (n > 0 && $urandom_range(0, 5) == 0) ? int'($urandom_range(1, n)) : 0;
      run_cmd(4'($urandom), 1'($urandom), c, 8'($urandom), ab);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
